alu_bist_sequencer: RTL

//   Self-test engine for the 4-bit ALU. Sweeps every {S,A,B} vector (4096) into the ALU's inputs.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_bist_sequencer_if.sv | 13 +
 rtl/alu_ref_model.sv | 40 ++++
 rtl/alu_bist_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test engine: opcode map, datapath widths
// and the sequencer state encoding.
package alu_pkg;
    localparam int ALU_W = 4;
    localparam int RES_W = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_DEC  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_PASA = 4'd13;
    localparam logic [3:0] OP_PASB = 4'd14;
    localparam logic [3:0] OP_ZERO = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/alu_bist_sequencer_if.sv
// Stimulus/response bus between the self-test sequencer (master) and the ALU
// under test (slave).
interface alu_bist_sequencer_if;
    import alu_pkg::*;

    logic [ALU_W-1:0] alu_s;
    logic [ALU_W-1:0] alu_a;
    logic [ALU_W-1:0] alu_b;
    logic [RES_W-1:0] alu_result;

    modport master (output alu_s, output alu_a, output alu_b, input alu_result);
    modport slave  (input alu_s, input alu_a, input alu_b, output alu_result);
endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU; arithmetic is zero-extended to
// 5 bits and wraps mod 32, so bit4 carries the borrow for SUB/DEC.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_s,
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    output logic [RES_W-1:0] o_result
);
    logic [RES_W-1:0] w_a;
    logic [RES_W-1:0] w_b;

    assign w_a = {1'b0, i_a};
    assign w_b = {1'b0, i_b};

    // Opcode decode to expected 5-bit result
    always_comb begin
        o_result = 5'd0;
        case (i_s)
            OP_ADD:  o_result = w_a + w_b;
            OP_SUB:  o_result = w_a - w_b;
            OP_AND:  o_result = {1'b0, i_a & i_b};
            OP_OR:   o_result = {1'b0, i_a | i_b};
            OP_XOR:  o_result = {1'b0, i_a ^ i_b};
            OP_NOT:  o_result = {1'b0, ~i_a};
            OP_NAND: o_result = {1'b0, ~(i_a & i_b)};
            OP_NOR:  o_result = {1'b0, ~(i_a | i_b)};
            OP_XNOR: o_result = {1'b0, ~(i_a ^ i_b)};
            OP_INC:  o_result = w_a + 5'd1;
            OP_DEC:  o_result = w_a - 5'd1;
            OP_SHL:  o_result = {i_a, 1'b0};
            OP_SHR:  o_result = {2'b00, i_a[3:1]};
            OP_PASA: o_result = w_a;
            OP_PASB: o_result = w_b;
            OP_ZERO: o_result = 5'd0;
            default: o_result = 5'd0;
        endcase
    end
endmodule

// File: rtl/alu_bist_sequencer.sv
// Built-in self-test sequencer: sweeps all 4096 {S,A,B} vectors into the ALU,
// checks each settled result against the golden model and logs mismatches.
module alu_bist_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int STOP_ON_FAIL  = 0,
    parameter int ERR_W         = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    alu_bist_sequencer_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [ERR_W-1:0]            err_count,
    output logic [11:0]                 first_fail,
    output logic                        first_fail_valid
);
    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    logic [11:0]        r_idx;
    logic [WAIT_W-1:0]  r_wait;
    logic [ERR_W-1:0]   r_err;
    logic [11:0]        r_ff;
    logic               r_ffv;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic [RES_W-1:0]   w_expected;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_last;

    alu_ref_model u_ref (
        .i_s      (r_idx[11:8]),
        .i_a      (r_idx[7:4]),
        .i_b      (r_idx[3:0]),
        .o_result (w_expected)
    );

    assign w_mismatch = (bus.alu_result != w_expected);
    assign w_last     = (r_idx == 12'hFFF) || ((STOP_ON_FAIL != 0) && w_mismatch);

    // Saturating error count including the vector currently being checked
    always_comb begin
        if (w_mismatch && !(&r_err)) begin
            w_err_next = r_err + ERR_W'(1);
        end else begin
            w_err_next = r_err;
        end
    end

    // Sequencer FSM, vector index, settle counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 12'd0;
            r_wait  <= '0;
            r_err   <= '0;
            r_ff    <= 12'd0;
            r_ffv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_WAIT;
                        r_idx   <= 12'd0;
                        r_wait  <= '0;
                        r_err   <= '0;
                        r_ffv   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_wait == WAIT_LAST) begin
                        r_wait  <= '0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_wait  <= r_wait + WAIT_W'(1);
                    end
                end
                ST_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_ffv) begin
                        r_ff  <= r_idx;
                        r_ffv <= 1'b1;
                    end
                    // Final vector (or early stop) freezes alu_* on the last one checked
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == {ERR_W{1'b0}});
                    end else begin
                        r_idx   <= r_idx + 12'd1;
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_s        = r_idx[11:8];
    assign bus.alu_a        = r_idx[7:4];
    assign bus.alu_b        = r_idx[3:0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail       = r_ff;
    assign first_fail_valid = r_ffv;
endmodule
